pc_gen: RTL and testbench

Parametrised program-counter generator for the pipelined MIPS core. Holds the fetch PC register and selects the next PC from sequential fetch, ID-stage jumps, EX-stage branch resolution, and misalignment traps. It also produces the pipeline flush signals. Sits at the front of IF, feeding instruction memory and the IF/ID register. It replaces the single-cycle combinational next-PC logic.

---
 rtl/pc_gen_pkg.sv | 18 +
 rtl/pc_gen_if.sv | 41 ++++
 rtl/pc_btb.sv | 68 ++++++
 rtl/pc_gen.sv | 121 ++++++++++++
 tb/tb_pc_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch program-counter generator.
// Holds the next-PC select encoding and the default reset / trap addresses.
package pc_gen_pkg;

   typedef enum logic [2:0] {
      SEL_EXFIX = 3'd0,
      SEL_TRAP  = 3'd1,
      SEL_JR    = 3'd2,
      SEL_J     = 3'd3,
      SEL_HOLD  = 3'd4,
      SEL_PRED  = 3'd5,
      SEL_SEQ   = 3'd6
   } pc_sel_e;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_gen_if.sv
// Bundle of the redirect requests coming into pc_gen and the fetch/flush
// results going out; slave is the pc_gen side, master the pipeline side.
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall_i;
   logic            id_jump_i;
   logic [25:0]     id_jidx_i;
   logic [XLEN-1:0] id_pc4_i;
   logic            id_jr_i;
   logic [XLEN-1:0] id_jr_tgt_i;
   logic            ex_branch_i;
   logic            ex_taken_i;
   logic [15:0]     ex_imm_i;
   logic [XLEN-1:0] ex_pc4_i;
   logic            ex_pred_taken_i;
   logic [XLEN-1:0] ex_pred_tgt_i;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] pc4_o;
   logic            pred_taken_o;
   logic [XLEN-1:0] pred_tgt_o;
   logic            flush_ifid_o;
   logic            flush_idex_o;
   logic            trap_o;

   modport slave (
      input  stall_i, id_jump_i, id_jidx_i, id_pc4_i, id_jr_i, id_jr_tgt_i,
             ex_branch_i, ex_taken_i, ex_imm_i, ex_pc4_i, ex_pred_taken_i,
             ex_pred_tgt_i,
      output pc_o, pc4_o, pred_taken_o, pred_tgt_o, flush_ifid_o,
             flush_idex_o, trap_o
   );

   modport master (
      output stall_i, id_jump_i, id_jidx_i, id_pc4_i, id_jr_i, id_jr_tgt_i,
             ex_branch_i, ex_taken_i, ex_imm_i, ex_pc4_i, ex_pred_taken_i,
             ex_pred_tgt_i,
      input  pc_o, pc4_o, pred_taken_o, pred_tgt_o, flush_ifid_o,
             flush_idex_o, trap_o
   );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// write/invalidate from the resolving EX branch. Lookups see pre-update state.
module pc_btb #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:2] lookup_pc,
   output logic            hit,
   output logic [XLEN-1:0] hit_tgt,
   input  logic            upd_en,
   input  logic            upd_taken,
   input  logic [XLEN-1:2] upd_pc,
   input  logic [XLEN-1:0] upd_tgt
);
   localparam int IDXW = $clog2(DEPTH);
   localparam int TAGW = XLEN - IDXW - 2;

   logic [DEPTH-1:0] valid_r;
   logic [TAGW-1:0]  tag_r [DEPTH];
   logic [XLEN-1:0]  tgt_r [DEPTH];

   logic [IDXW-1:0] rd_idx_s;
   logic [IDXW-1:0] wr_idx_s;
   logic [TAGW-1:0] rd_tag_s;
   logic [TAGW-1:0] wr_tag_s;

   assign rd_idx_s = lookup_pc[IDXW+1:2];
   assign rd_tag_s = lookup_pc[XLEN-1:IDXW+2];
   assign wr_idx_s = upd_pc[IDXW+1:2];
   assign wr_tag_s = upd_pc[XLEN-1:IDXW+2];

   // Lookup of the current fetch address.
   always_comb begin
      hit     = 1'b0;
      hit_tgt = '0;
      if (valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s)) begin
         hit     = 1'b1;
         hit_tgt = tgt_r[rd_idx_s];
      end else begin
         hit     = 1'b0;
         hit_tgt = '0;
      end
   end

   // Valid bits: set on a taken branch, dropped when a matching branch falls through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
      end else if (upd_en) begin
         if (upd_taken) begin
            valid_r[wr_idx_s] <= 1'b1;
         end else if (tag_r[wr_idx_s] == wr_tag_s) begin
            valid_r[wr_idx_s] <= 1'b0;
         end
      end
   end

   // Tag and target payload; meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (upd_en && upd_taken) begin
         tag_r[wr_idx_s] <= wr_tag_s;
         tgt_r[wr_idx_s] <= upd_tgt;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with prioritised next-PC selection and pipeline flushes.
// Optional branch target buffer is built when PC_GEN_BTB_EN is defined.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = XLEN'(DEF_RESET_PC),
   parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(DEF_EXC_VECTOR),
   parameter int              BTB_DEPTH  = 8
) (
   input logic     clk,
   input logic     rst_n,
   pc_gen_if.slave bus
);

   if (XLEN < 32 || BTB_DEPTH < 2 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0) begin : g_param_err
      $error("pc_gen: XLEN must be >= 32 and BTB_DEPTH a power of two >= 2");
   end

   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] pc4_s;
   logic [XLEN-1:0] imm_ext_s;
   logic [XLEN-1:0] br_tgt_s;
   logic [XLEN-1:0] fix_tgt_s;
   logic [XLEN-1:0] jmp_tgt_s;
   logic [XLEN-1:0] next_pc_s;
   logic            mispredict_s;
   logic            pred_taken_s;
   logic [XLEN-1:0] pred_tgt_s;
   pc_sel_e         sel_s;

   assign pc4_s     = pc_r + XLEN'(4);
   assign imm_ext_s = {{(XLEN-16){bus.ex_imm_i[15]}}, bus.ex_imm_i};
   assign br_tgt_s  = bus.ex_pc4_i + {imm_ext_s[XLEN-3:0], 2'b00};
   assign fix_tgt_s = bus.ex_taken_i ? br_tgt_s : bus.ex_pc4_i;
   assign jmp_tgt_s = {bus.id_pc4_i[XLEN-1:28], bus.id_jidx_i, 2'b00};

   assign mispredict_s = bus.ex_branch_i &&
                         ((bus.ex_taken_i != bus.ex_pred_taken_i) ||
                          (bus.ex_taken_i && bus.ex_pred_taken_i &&
                           (bus.ex_pred_tgt_i != br_tgt_s)));

`ifdef PC_GEN_BTB_EN
   logic [XLEN-1:2] ex_pc_s;

   // The branch's own address is one word below the PC+4 it carries.
   assign ex_pc_s = bus.ex_pc4_i[XLEN-1:2] - (XLEN-2)'(1);

   pc_btb #(
      .XLEN  (XLEN),
      .DEPTH (BTB_DEPTH)
   ) u_btb (
      .clk       (clk),
      .rst_n     (rst_n),
      .lookup_pc (pc_r[XLEN-1:2]),
      .hit       (pred_taken_s),
      .hit_tgt   (pred_tgt_s),
      .upd_en    (bus.ex_branch_i),
      .upd_taken (bus.ex_taken_i),
      .upd_pc    (ex_pc_s),
      .upd_tgt   (br_tgt_s)
   );
`else
   assign pred_taken_s = 1'b0;
   assign pred_tgt_s   = '0;
`endif

   // Redirect priority: EX correction beats everything, ID redirects beat a stall.
   always_comb begin
      sel_s = SEL_SEQ;
      if (mispredict_s) begin
         sel_s = SEL_EXFIX;
      end else if (bus.id_jr_i && (bus.id_jr_tgt_i[1:0] != 2'b00)) begin
         sel_s = SEL_TRAP;
      end else if (bus.id_jr_i) begin
         sel_s = SEL_JR;
      end else if (bus.id_jump_i) begin
         sel_s = SEL_J;
      end else if (bus.stall_i) begin
         sel_s = SEL_HOLD;
      end else if (pred_taken_s) begin
         sel_s = SEL_PRED;
      end else begin
         sel_s = SEL_SEQ;
      end
   end

   // Next-PC mux driven by the select.
   always_comb begin
      next_pc_s = pc4_s;
      case (sel_s)
         SEL_EXFIX: next_pc_s = fix_tgt_s;
         SEL_TRAP:  next_pc_s = EXC_VECTOR;
         SEL_JR:    next_pc_s = bus.id_jr_tgt_i;
         SEL_J:     next_pc_s = jmp_tgt_s;
         SEL_HOLD:  next_pc_s = pc_r;
         SEL_PRED:  next_pc_s = pred_tgt_s;
         SEL_SEQ:   next_pc_s = pc4_s;
         default:   next_pc_s = pc4_s;
      endcase
   end

   // Fetch PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= next_pc_s;
      end
   end

   assign bus.pc_o         = pc_r;
   assign bus.pc4_o        = pc4_s;
   assign bus.pred_taken_o = pred_taken_s;
   assign bus.pred_tgt_o   = pred_tgt_s;
   assign bus.flush_ifid_o = (sel_s == SEL_EXFIX) || (sel_s == SEL_TRAP) ||
                             (sel_s == SEL_JR)    || (sel_s == SEL_J);
   assign bus.flush_idex_o = (sel_s == SEL_EXFIX);
   assign bus.trap_o       = (sel_s == SEL_TRAP);

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen; with PC_GEN_BTB_EN defined it runs
// the BTB training/invalidate table instead of the predict-not-taken table.
module tb_pc_gen;

   localparam logic [1:0] M_ABS  = 2'd0;
   localparam logic [1:0] M_SEQ  = 2'd1;
   localparam logic [1:0] M_HOLD = 2'd2;

   typedef struct {
      logic        stall;
      logic        jump;
      logic [25:0] jidx;
      logic [31:0] id_pc4;
      logic        jr;
      logic [31:0] jr_tgt;
      logic        br;
      logic        tk;
      logic [15:0] imm;
      logic [31:0] ex_pc4;
      logic        pt;
      logic [31:0] ptgt;
      logic        e_ifid;
      logic        e_idex;
      logic        e_trap;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic [1:0]  mode;
      logic [31:0] e_pc;
   } vec_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   logic [31:0] cur_pc;
   vec_t tbl[$];

   pc_gen_if #(.XLEN(32)) bus ();

   pc_gen #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic stall, input logic jump, input logic [25:0] jidx,
      input logic [31:0] id_pc4, input logic jr, input logic [31:0] jr_tgt,
      input logic br, input logic tk, input logic [15:0] imm,
      input logic [31:0] ex_pc4, input logic pt, input logic [31:0] ptgt,
      input logic e_ifid, input logic e_idex, input logic e_trap,
      input logic e_pt, input logic [31:0] e_ptgt,
      input logic [1:0] mode, input logic [31:0] e_pc);
      vec_t v;
      v.stall = stall; v.jump = jump; v.jidx = jidx; v.id_pc4 = id_pc4;
      v.jr = jr; v.jr_tgt = jr_tgt; v.br = br; v.tk = tk; v.imm = imm;
      v.ex_pc4 = ex_pc4; v.pt = pt; v.ptgt = ptgt; v.e_ifid = e_ifid;
      v.e_idex = e_idex; v.e_trap = e_trap; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
      v.mode = mode; v.e_pc = e_pc;
      return v;
   endfunction

   function automatic vec_t idle(input logic [1:0] mode);
      return mk(1'b0, 1'b0, 26'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0,
                1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, mode, 32'h0);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.stall_i = 1'b0; bus.id_jump_i = 1'b0; bus.id_jidx_i = 26'h0;
      bus.id_pc4_i = 32'h0; bus.id_jr_i = 1'b0; bus.id_jr_tgt_i = 32'h0;
      bus.ex_branch_i = 1'b0; bus.ex_taken_i = 1'b0; bus.ex_imm_i = 16'h0;
      bus.ex_pc4_i = 32'h0; bus.ex_pred_taken_i = 1'b0; bus.ex_pred_tgt_i = 32'h0;
   endtask

   // Drive one cycle of requests, check same-cycle outputs, then the next PC.
   task automatic apply(input vec_t v, input string tag);
      logic [31:0] exp_pc;
      logic [31:0] exp_pc4;
      bus.stall_i = v.stall; bus.id_jump_i = v.jump; bus.id_jidx_i = v.jidx;
      bus.id_pc4_i = v.id_pc4; bus.id_jr_i = v.jr; bus.id_jr_tgt_i = v.jr_tgt;
      bus.ex_branch_i = v.br; bus.ex_taken_i = v.tk; bus.ex_imm_i = v.imm;
      bus.ex_pc4_i = v.ex_pc4; bus.ex_pred_taken_i = v.pt; bus.ex_pred_tgt_i = v.ptgt;
      #1;
      exp_pc4 = cur_pc + 32'd4;
      chk({tag, " flush_ifid"}, 32'(bus.flush_ifid_o), 32'(v.e_ifid));
      chk({tag, " flush_idex"}, 32'(bus.flush_idex_o), 32'(v.e_idex));
      chk({tag, " trap"},       32'(bus.trap_o),       32'(v.e_trap));
      chk({tag, " pc4"},        bus.pc4_o,             exp_pc4);
      chk({tag, " pred_taken"}, 32'(bus.pred_taken_o), 32'(v.e_pt));
      chk({tag, " pred_tgt"},   bus.pred_tgt_o,        v.e_ptgt);
      @(posedge clk);
      #1;
      case (v.mode)
         M_SEQ:   exp_pc = exp_pc4;
         M_HOLD:  exp_pc = cur_pc;
         default: exp_pc = v.e_pc;
      endcase
      chk({tag, " next_pc"}, bus.pc_o, exp_pc);
      cur_pc = exp_pc;
      clear_inputs();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      cur_pc = 32'h0;
      rst_n  = 1'b0;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("rst pc",         bus.pc_o,               32'h0);
      chk("rst pc4",        bus.pc4_o,              32'h4);
      chk("rst flush_ifid", 32'(bus.flush_ifid_o),  32'h0);
      chk("rst flush_idex", 32'(bus.flush_idex_o),  32'h0);
      chk("rst trap",       32'(bus.trap_o),        32'h0);
      chk("rst pred_taken", 32'(bus.pred_taken_o),  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("first fetch", bus.pc_o, 32'h0);

`ifndef PC_GEN_BTB_EN
      //          stall jump jidx     id_pc4         jr   jr_tgt         br   tk   imm       ex_pc4       pt   ptgt         ifid idex trap pt   ptgt  mode    e_pc
      tbl.push_back(idle(M_SEQ));
      tbl.push_back(idle(M_SEQ));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b1,16'hFFFE,32'h40,      1'b0,32'h0,      1'b1,1'b1,1'b0,1'b0,32'h0,M_ABS, 32'h38));
      tbl.push_back(idle(M_SEQ));
      tbl.push_back(mk(1'b1,1'b1,26'h100,32'h1000_0010,1'b0,32'h0,        1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b1,1'b0,1'b0,1'b0,32'h0,M_ABS, 32'h1000_0400));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b1,32'h102,      1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b1,1'b0,1'b1,1'b0,32'h0,M_ABS, 32'h80));
      tbl.push_back(idle(M_SEQ));
      tbl.push_back(idle(M_HOLD));
      tbl[$].stall = 1'b1;
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b1,32'h2000,     1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b1,1'b0,1'b0,1'b0,32'h0,M_ABS, 32'h2000));
      tbl.push_back(mk(1'b0,1'b1,26'h3,  32'h0,        1'b1,32'h3000,     1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b1,1'b0,1'b0,1'b0,32'h0,M_ABS, 32'h3000));
      tbl.push_back(mk(1'b0,1'b1,26'h55, 32'h0,        1'b0,32'h0,        1'b1,1'b1,16'h0010,32'h500,     1'b0,32'h0,      1'b1,1'b1,1'b0,1'b0,32'h0,M_ABS, 32'h540));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b0,16'h0010,32'h600,     1'b0,32'h0,      1'b0,1'b0,1'b0,1'b0,32'h0,M_SEQ, 32'h0));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b0,16'h0010,32'h600,     1'b1,32'h900,    1'b1,1'b1,1'b0,1'b0,32'h0,M_ABS, 32'h600));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b1,16'h0004,32'h700,     1'b1,32'h710,    1'b0,1'b0,1'b0,1'b0,32'h0,M_SEQ, 32'h0));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b1,16'h0004,32'h700,     1'b1,32'h720,    1'b1,1'b1,1'b0,1'b0,32'h0,M_ABS, 32'h710));
      tbl.push_back(mk(1'b1,1'b0,26'h0,  32'h0,        1'b1,32'h102,      1'b1,1'b1,16'h0001,32'h100,     1'b0,32'h0,      1'b1,1'b1,1'b0,1'b0,32'h0,M_ABS, 32'h104));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b1,16'h7FFF,32'h10,      1'b0,32'h0,      1'b1,1'b1,1'b0,1'b0,32'h0,M_ABS, 32'h2000C));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b0,1'b1,16'h0010,32'h200,     1'b0,32'h0,      1'b0,1'b0,1'b0,1'b0,32'h0,M_SEQ, 32'h0));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b1,32'hFFFF_FFFC,1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b1,1'b0,1'b0,1'b0,32'h0,M_ABS, 32'hFFFF_FFFC));
      tbl.push_back(idle(M_ABS));
`else
      for (int i = 0; i < 8; i++) tbl.push_back(idle(M_SEQ));
      tbl.push_back(idle(M_SEQ));
      tbl.push_back(idle(M_SEQ));
      // Branch at 0x20 resolves taken to 0x100, unpredicted.
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b1,16'h0037,32'h24,      1'b0,32'h0,      1'b1,1'b1,1'b0,1'b0,32'h0,  M_ABS, 32'h100));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b1,32'h20,       1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b1,1'b0,1'b0,1'b0,32'h0,  M_ABS, 32'h20));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b0,1'b0,1'b0,1'b1,32'h100,M_ABS, 32'h100));
      tbl.push_back(idle(M_SEQ));
      // EX confirms the prediction: no flush.
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b1,16'h0037,32'h24,      1'b1,32'h100,    1'b0,1'b0,1'b0,1'b0,32'h0,  M_SEQ, 32'h0));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b1,32'h20,       1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b1,1'b0,1'b0,1'b0,32'h0,  M_ABS, 32'h20));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b0,1'b0,1'b0,1'b1,32'h100,M_ABS, 32'h100));
      // Resolves not-taken: flush, fall through, entry invalidated.
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b0,32'h0,        1'b1,1'b0,16'h0037,32'h24,      1'b1,32'h100,    1'b1,1'b1,1'b0,1'b0,32'h0,  M_ABS, 32'h24));
      tbl.push_back(mk(1'b0,1'b0,26'h0,  32'h0,        1'b1,32'h20,       1'b0,1'b0,16'h0,   32'h0,       1'b0,32'h0,      1'b1,1'b0,1'b0,1'b0,32'h0,  M_ABS, 32'h20));
      tbl.push_back(idle(M_SEQ));
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("v%0d", i));
      end

      // Reset asserted while a jump redirect is pending must abort it.
      apply(idle(M_SEQ), "pre_rst");
      bus.id_jump_i = 1'b1;
      bus.id_jidx_i = 26'h40;
      bus.id_pc4_i  = 32'h0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst pc", bus.pc_o, 32'h0);
      clear_inputs();
      #1;
      chk("midrst flush_ifid", 32'(bus.flush_ifid_o), 32'h0);
      chk("midrst pc4", bus.pc4_o, 32'h4);
      @(posedge clk);
      #1;
      chk("midrst hold pc", bus.pc_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post rst first fetch", bus.pc_o, 32'h0);
      cur_pc = 32'h0;
      apply(idle(M_SEQ), "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
